// File: rtl/mc_ctrl_unit_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state codes, opcode/funct
// values, control-field encodings and instruction-class decode helpers.
package mc_ctrl_unit_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_FETCH  = 4'd1;
  localparam state_t S_DECODE = 4'd2;
  localparam state_t S_MEMADR = 4'd3;
  localparam state_t S_MEMRD  = 4'd4;
  localparam state_t S_MEMWB  = 4'd5;
  localparam state_t S_MEMWR  = 4'd6;
  localparam state_t S_EXEC   = 4'd7;
  localparam state_t S_ALUWB  = 4'd8;
  localparam state_t S_BRANCH = 4'd9;
  localparam state_t S_JUMP   = 4'd10;
  localparam state_t S_JAL    = 4'd11;
  localparam state_t S_JR     = 4'd12;
  localparam state_t S_TRAP   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [3:0] ALU_AND = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_ADD = 4'd5;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd10;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HI16 = 2'b10;

  localparam logic [1:0] RFIN_PC4 = 2'b00;
  localparam logic [1:0] RFIN_DR  = 2'b01;
  localparam logic [1:0] RFIN_ALU = 2'b10;
  localparam logic [1:0] RFIN_EXT = 2'b11;

  localparam logic [1:0] RFOUT_RD = 2'b00;
  localparam logic [1:0] RFOUT_RT = 2'b01;
  localparam logic [1:0] RFOUT_31 = 2'b10;

  typedef enum logic [3:0] {
    C_RALU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR, C_ILL
  } iclass_t;

  function automatic iclass_t decode_class(input logic [5:0] op, input logic [5:0] funct);
    iclass_t c;
    c = C_ILL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: c = C_RALU;
          FN_JR:                                   c = C_JR;
          default:                                 c = C_ILL;
        endcase
      end
      OP_ORI:  c = C_ORI;
      OP_LUI:  c = C_LUI;
      OP_LW:   c = C_LW;
      OP_SW:   c = C_SW;
      OP_BEQ:  c = C_BEQ;
      OP_BNE:  c = C_BNE;
      OP_J:    c = C_J;
      OP_JAL:  c = C_JAL;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] alu_of_funct(input logic [5:0] funct);
    logic [3:0] a;
    a = 4'd0;
    case (funct)
      FN_ADDU: a = ALU_ADD;
      FN_SUBU: a = ALU_SUB;
      FN_AND:  a = ALU_AND;
      FN_OR:   a = ALU_OR;
      FN_SLT:  a = ALU_SLT;
      default: a = 4'd0;
    endcase
    return a;
  endfunction

  function automatic logic [1:0] ext_of(input iclass_t c);
    logic [1:0] e;
    e = EXT_ZERO;
    case (c)
      C_LW, C_SW, C_BEQ, C_BNE: e = EXT_SIGN;
      C_LUI:                    e = EXT_HI16;
      default:                  e = EXT_ZERO;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mc_ctrl_unit_if.sv
// Controller <-> datapath bundle: IR fields, flags and memory handshakes in,
// mux selects, write enables, status out.
interface mc_ctrl_unit_if #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               imem_ready;
  logic               dmem_ready;
  logic               B_sel;
  logic [1:0]         RFin_sel;
  logic [1:0]         RFout_sel;
  logic               RFWr;
  logic               DMWr;
  logic               PCWr;
  logic               IRWr;
  logic [1:0]         npcop;
  logic [1:0]         extop;
  logic [ALUOP_W-1:0] aluop;
  logic               trap;
  logic [CNT_W-1:0]   instr_cnt;

  modport master (
    input  op, funct, zero, imem_ready, dmem_ready,
    output B_sel, RFin_sel, RFout_sel, RFWr, DMWr, PCWr, IRWr,
           npcop, extop, aluop, trap, instr_cnt
  );

  modport slave (
    output op, funct, zero, imem_ready, dmem_ready,
    input  B_sel, RFin_sel, RFout_sel, RFWr, DMWr, PCWr, IRWr,
           npcop, extop, aluop, trap, instr_cnt
  );
endinterface

// File: rtl/mc_ctrl_unit_wait_timer.sv
// Handshake wait counter: counts consecutive not-ready cycles in a wait state and
// flags the cycle on which the TMO_CYC-th not-ready cycle occurs.
module mc_ctrl_unit_wait_timer #(
  parameter int TMO_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  output logic timeout
);
  localparam int CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] cnt;

  // Every wait exits on ready, so clearing on ready also covers MEMWR -> FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cnt <= '0;
    else if (!active || ready) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  assign timeout = active && !ready && (cnt == CW'(TMO_CYC - 1));
endmodule

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle MIPS controller: registered state, Moore-style control decode from
// state and IR fields, memory handshake waits with timeout trap, retired-instr count.
module mc_ctrl_unit
  import mc_ctrl_unit_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int MEM_HS  = 1,
  parameter int TMO_CYC = 255,
  parameter int CNT_W   = 32
) (
  input logic             clk,
  input logic             rst,
  mc_ctrl_unit_if.master  bus
);
  state_t           state, state_nx;
  iclass_t          cls;
  logic [1:0]       ext_code;
  logic             imem_rdy, dmem_rdy;
  logic             wait_active, wait_ready, timeout, retire;
  logic [CNT_W-1:0] cnt_q;

  assign cls      = decode_class(bus.op, bus.funct);
  assign ext_code = ext_of(cls);
  assign imem_rdy = (MEM_HS == 0) ? 1'b1 : bus.imem_ready;
  assign dmem_rdy = (MEM_HS == 0) ? 1'b1 : bus.dmem_ready;

  assign wait_active = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign wait_ready  = (state == S_FETCH) ? imem_rdy : dmem_rdy;

  mc_ctrl_unit_wait_timer #(.TMO_CYC(TMO_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .active  (wait_active),
    .ready   (wait_ready),
    .timeout (timeout)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = S_FETCH;
      S_FETCH:  if (imem_rdy) state_nx = S_DECODE; else if (timeout) state_nx = S_TRAP;
      S_DECODE: begin
        case (cls)
          C_RALU, C_ORI, C_LUI: state_nx = S_EXEC;
          C_LW, C_SW:           state_nx = S_MEMADR;
          C_BEQ, C_BNE:         state_nx = S_BRANCH;
          C_J:                  state_nx = S_JUMP;
          C_JAL:                state_nx = S_JAL;
          C_JR:                 state_nx = S_JR;
          default:              state_nx = S_TRAP;
        endcase
      end
      S_MEMADR: state_nx = (cls == C_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (dmem_rdy) state_nx = S_MEMWB; else if (timeout) state_nx = S_TRAP;
      S_MEMWR:  if (dmem_rdy) state_nx = S_FETCH; else if (timeout) state_nx = S_TRAP;
      S_EXEC:   state_nx = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_nx = S_FETCH;
      S_TRAP:   state_nx = S_TRAP;
      default:  state_nx = S_TRAP;
    endcase
  end

  assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH) ||
                  (state == S_JUMP)  || (state == S_JAL)   || (state == S_JR)     ||
                  ((state == S_MEMWR) && dmem_rdy);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      if (retire) cnt_q <= cnt_q + 1'b1;
    end
  end

  // The extender code is kept stable in every state whose datapath consumes EXT.
  always_comb begin
    bus.B_sel     = 1'b0;
    bus.RFin_sel  = RFIN_PC4;
    bus.RFout_sel = RFOUT_RD;
    bus.RFWr      = 1'b0;
    bus.DMWr      = 1'b0;
    bus.PCWr      = 1'b0;
    bus.IRWr      = 1'b0;
    bus.npcop     = NPC_PC4;
    bus.extop     = EXT_ZERO;
    bus.aluop     = '0;
    case (state)
      S_FETCH: begin
        bus.PCWr = imem_rdy;
        bus.IRWr = imem_rdy;
      end
      S_DECODE: bus.extop = ext_code;
      S_MEMADR: begin
        bus.B_sel = 1'b1;
        bus.aluop = ALUOP_W'(ALU_ADD);
        bus.extop = ext_code;
      end
      S_MEMWB: begin
        bus.RFWr      = 1'b1;
        bus.RFin_sel  = RFIN_DR;
        bus.RFout_sel = RFOUT_RT;
      end
      S_MEMWR: bus.DMWr = 1'b1;
      S_EXEC: begin
        bus.extop = ext_code;
        if (cls == C_RALU) begin
          bus.aluop = ALUOP_W'(alu_of_funct(bus.funct));
        end else if (cls == C_ORI) begin
          bus.B_sel = 1'b1;
          bus.aluop = ALUOP_W'(ALU_OR);
        end
      end
      S_ALUWB: begin
        bus.RFWr      = 1'b1;
        bus.extop     = ext_code;
        bus.RFin_sel  = (cls == C_LUI)  ? RFIN_EXT : RFIN_ALU;
        bus.RFout_sel = (cls == C_RALU) ? RFOUT_RD : RFOUT_RT;
      end
      S_BRANCH: begin
        bus.aluop = ALUOP_W'(ALU_SUB);
        bus.npcop = NPC_BR;
        bus.PCWr  = (cls == C_BNE) ? !bus.zero : bus.zero;
      end
      S_JUMP: begin
        bus.npcop = NPC_J;
        bus.PCWr  = 1'b1;
      end
      S_JAL: begin
        bus.npcop     = NPC_J;
        bus.PCWr      = 1'b1;
        bus.RFWr      = 1'b1;
        bus.RFin_sel  = RFIN_PC4;
        bus.RFout_sel = RFOUT_31;
      end
      S_JR: begin
        bus.npcop = NPC_JR;
        bus.PCWr  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.trap      = (state == S_TRAP);
  assign bus.instr_cnt = cnt_q;
endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Scoreboard bench: stimulus tasks push the per-cycle control word expected from an
// instruction-level model; a negedge monitor pops and compares every cycle.
module tb_mc_ctrl_unit;
  localparam int TMO = 4;
  localparam int CW  = 8;

  localparam int K_R = 0, K_ORI = 1, K_LUI = 2, K_LW = 3, K_SW = 4, K_BEQ = 5,
                 K_BNE = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_ILL = 10;

  typedef struct packed {
    logic          b_sel;
    logic [1:0]    rfin;
    logic [1:0]    rfout;
    logic          rfwr;
    logic          dmwr;
    logic          pcwr;
    logic          irwr;
    logic [1:0]    npc;
    logic [1:0]    ext;
    logic [3:0]    alu;
    logic          trap;
    logic [CW-1:0] cnt;
  } ctl_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mc_ctrl_unit_if #(.ALUOP_W(4), .CNT_W(CW)) bus();

  mc_ctrl_unit #(.ALUOP_W(4), .MEM_HS(1), .TMO_CYC(TMO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  ctl_t          q[$];
  string         tq[$];
  int            n_chk  = 0;
  int            n_fail = 0;
  logic [CW-1:0] m_cnt  = '0;

  logic [5:0] rop [14] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h0D,
                           6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
  logic [5:0] rfn [14] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h00,
                           6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      if (f == 6'h21 || f == 6'h23 || f == 6'h24 || f == 6'h25 || f == 6'h2A) return K_R;
      if (f == 6'h08) return K_JR;
      return K_ILL;
    end
    case (o)
      6'h0D: return K_ORI;
      6'h0F: return K_LUI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h05: return K_BNE;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [1:0] ext_for(input logic [5:0] o);
    case (o)
      6'h23, 6'h2B, 6'h04, 6'h05: return 2'b01;
      6'h0F:                      return 2'b10;
      default:                    return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] alu_r(input logic [5:0] f);
    case (f)
      6'h21: return 4'd5;
      6'h23: return 4'd6;
      6'h24: return 4'd1;
      6'h25: return 4'd2;
      default: return 4'd10;
    endcase
  endfunction

  function automatic ctl_t sample();
    ctl_t a;
    a.b_sel = bus.B_sel;   a.rfin = bus.RFin_sel; a.rfout = bus.RFout_sel;
    a.rfwr  = bus.RFWr;    a.dmwr = bus.DMWr;     a.pcwr  = bus.PCWr;
    a.irwr  = bus.IRWr;    a.npc  = bus.npcop;    a.ext   = bus.extop;
    a.alu   = bus.aluop;   a.trap = bus.trap;     a.cnt   = bus.instr_cnt;
    return a;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      ctl_t e, a;
      string t;
      e = q.pop_front();
      t = tq.pop_front();
      a = sample();
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: actual=%h required=%h", t, $time, a, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input ctl_t e, input string tag);
    e.cnt = m_cnt;
    q.push_back(e);
    tq.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_trap(input string tag);
    ctl_t e;
    for (int i = 0; i < 3; i++) begin
      bus.imem_ready = 1'($urandom);
      bus.dmem_ready = 1'($urandom);
      e = '0;
      e.trap = 1'b1;
      push(e, tag);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_cnt = '0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    push('0, "reset_a");
    push('0, "reset_b");
    chk("reset_cnt", 32'(bus.instr_cnt), 32'd0);
    chk("reset_trap", 32'(bus.trap), 32'd0);
    rst = 1'b1;
    push('0, "idle");
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int di, input int dd, input bit abort_wr);
    ctl_t e;
    int   k;
    bus.op = o; bus.funct = f; bus.zero = z;
    for (int i = 0; i < di && i < TMO; i++) begin
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'($urandom);
      push('0, "fetch_wait");
    end
    if (di >= TMO) begin
      do_trap("fetch_timeout");
      return;
    end
    bus.imem_ready = 1'b1;
    e = '0; e.pcwr = 1'b1; e.irwr = 1'b1;
    push(e, "fetch");
    bus.imem_ready = 1'($urandom);
    bus.dmem_ready = 1'($urandom);
    e = '0; e.ext = ext_for(o);
    push(e, "decode");
    k = kind_of(o, f);
    case (k)
      K_R, K_ORI, K_LUI: begin
        e = '0; e.ext = ext_for(o);
        if (k == K_R) e.alu = alu_r(f);
        if (k == K_ORI) begin e.b_sel = 1'b1; e.alu = 4'd2; end
        push(e, "exec");
        e = '0; e.ext = ext_for(o); e.rfwr = 1'b1;
        e.rfin  = (k == K_LUI) ? 2'b11 : 2'b10;
        e.rfout = (k == K_R)   ? 2'b00 : 2'b01;
        push(e, "aluwb");
        m_cnt++;
      end
      K_LW, K_SW: begin
        e = '0; e.b_sel = 1'b1; e.alu = 4'd5; e.ext = 2'b01;
        push(e, "memadr");
        for (int i = 0; i < dd && i < TMO; i++) begin
          bus.dmem_ready = 1'b0;
          if (abort_wr && k == K_SW && i == 2) begin
            #3;
            chk("dmwr_before_rst", 32'(bus.DMWr), 32'd1);
            rst = 1'b0;
            #1;
            chk("dmwr_async_drop", 32'(bus.DMWr), 32'd0);
            chk("async_cnt_clear", 32'(bus.instr_cnt), 32'd0);
            m_cnt = '0;
            @(posedge clk);
            #1;
            return;
          end
          e = '0; e.dmwr = (k == K_SW);
          push(e, (k == K_SW) ? "memwr_wait" : "memrd_wait");
        end
        if (dd >= TMO) begin
          do_trap("mem_timeout");
          return;
        end
        bus.dmem_ready = 1'b1;
        e = '0; e.dmwr = (k == K_SW);
        push(e, (k == K_SW) ? "memwr_done" : "memrd_done");
        if (k == K_SW) begin
          m_cnt++;
        end else begin
          e = '0; e.rfwr = 1'b1; e.rfin = 2'b01; e.rfout = 2'b01;
          push(e, "memwb");
          m_cnt++;
        end
      end
      K_BEQ, K_BNE: begin
        e = '0; e.alu = 4'd6; e.npc = 2'b01;
        e.pcwr = (k == K_BEQ) ? z : !z;
        push(e, "branch");
        m_cnt++;
      end
      K_J, K_JAL, K_JR: begin
        e = '0; e.pcwr = 1'b1;
        e.npc = (k == K_JR) ? 2'b11 : 2'b10;
        if (k == K_JAL) begin e.rfwr = 1'b1; e.rfin = 2'b00; e.rfout = 2'b10; end
        push(e, (k == K_J) ? "jump" : (k == K_JAL) ? "jal" : "jr");
        m_cnt++;
      end
      default: do_trap("illegal");
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx, di, dd;
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    run_instr(6'h00, 6'h21, 1'b0, 0, 0, 1'b0);
    chk("addu_retired", 32'(bus.instr_cnt), 32'd1);
    run_instr(6'h23, 6'h00, 1'b0, 0, 3, 1'b0);
    run_instr(6'h04, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr(6'h05, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr(6'h03, 6'h00, 1'b0, 1, 0, 1'b0);
    run_instr(6'h00, 6'h08, 1'b0, 0, 0, 1'b0);
    run_instr(6'h2B, 6'h00, 1'b1, 2, 3, 1'b0);
    run_instr(6'h0F, 6'h00, 1'b0, 3, 0, 1'b0);
    run_instr(6'h0D, 6'h00, 1'b0, 0, 0, 1'b0);
    chk("directed_retired", 32'(bus.instr_cnt), 32'd9);

    for (int n = 0; n < 300; n++) begin
      idx = $urandom_range(0, 13);
      di  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TMO - 1) : 0;
      dd  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, TMO - 1) : 0;
      run_instr(rop[idx], rfn[idx], 1'($urandom), di, dd, 1'b0);
    end

    run_instr(6'h00, 6'h21, 1'b0, TMO, 0, 1'b0);
    chk("trap_sticky", 32'(bus.trap), 32'd1);
    do_reset();
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);
    do_reset();
    run_instr(6'h00, 6'h00, 1'b0, 0, 0, 1'b0);
    do_reset();
    run_instr(6'h23, 6'h00, 1'b0, 0, TMO, 1'b0);
    do_reset();
    run_instr(6'h2B, 6'h00, 1'b0, 0, TMO + 2, 1'b1);
    do_reset();
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr(6'h2B, 6'h00, 1'b0, 0, TMO, 1'b0);

    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
